// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the handshaked data memory.
// Pulled in by dmem_array and dmem_handshake via import dmem_pkg::*.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int BYTE_W = 8;

    // Number of byte-offset bits inside one memory word.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / BYTE_W);
    endfunction

    // Latency counter width; always wide enough to hold LATENCY-1.
    function automatic int cnt_w(input int latency);
        return $clog2(latency) + 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte write enable and a registered read port.
// rdata only changes on a read access, so it holds steady while a response waits.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BE_W   = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_handshake.sv
// Word-organised data memory behind a valid/ready request/response handshake.
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module dmem_handshake
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
`ifdef DMEM_STATS_EN
    ,
    parameter int STAT_W  = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_be,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [STAT_W-1:0]      stat_reads,
    output logic [STAT_W-1:0]      stat_writes,
    output logic [STAT_W-1:0]      stat_errors
`endif
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int BE_W  = DATA_W / BYTE_W;
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_w(LATENCY);

    localparam logic [IDX_W-1:0] DEPTH_L   = IDX_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);

    dmem_state_e       state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              accept, access;
    logic              err_acc;
    logic              arr_en;
    logic [IDX_W-1:0]  widx;
    logic [DATA_W-1:0] arr_rdata;
    logic              req_ready_q;
    logic              rsp_err_q;
    logic              rd_sel_q;

    // Request latched at the accept edge
    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [BE_W-1:0]   be_p0;

    assign widx    = addr_p0[ADDR_W-1:OFF_W];
    assign err_acc = (addr_p0[OFF_W-1:0] != '0) || (widx >= DEPTH_L);
    assign arr_en  = access && !err_acc;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        access  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_START;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            // Registered so a retiring response blocks acceptance for that cycle
            req_ready_q <= (state_d == IDLE);
            if (access) begin
                rsp_err_q <= err_acc;
                rd_sel_q  <= !we_p0 && !err_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            be_p0    <= req_be;
        end
    end

    // Access stage: storage commit / registered read
    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (we_p0),
        .idx   (widx[AW-1:0]),
        .wdata (wdata_p0),
        .be    (be_p0),
        .rdata (arr_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rd_sel_q ? arr_rdata : '0;

`ifdef DMEM_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errors <= '0;
        end else if (access) begin
            if (err_acc) begin
                stat_errors <= sat_inc(stat_errors);
            end else if (we_p0) begin
                stat_writes <= sat_inc(stat_writes);
            end else begin
                stat_reads  <= sat_inc(stat_reads);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_handshake.sv
// Scoreboard bench for dmem_handshake: directed requests push expected responses,
// a negedge monitor pops and compares them, plus latency and hold checks.
module tb_dmem_handshake;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_STATS_EN
    logic [1:0]  stat_reads, stat_writes, stat_errors;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    logic        prev_v = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_e = 1'b0;

    dmem_handshake #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH   (64),
        .LATENCY (LAT)
`ifdef DMEM_STATS_EN
        ,
        .STAT_W  (2)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_errors (stat_errors)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Issue one request and return right after its accept edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e,
                          input bit push);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        while (req_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_accept: req_ready never rose for addr 0x%08h", addr);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = '0;
        if (push) sb.push_back('{exp_d, exp_e, cyc});
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                      input logic exp_e);
        do_req(1'b1, addr, data, be, 32'h0, exp_e, 1'b1);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e);
        do_req(1'b0, addr, 32'h0, 4'h0, exp_d, exp_e, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'h0);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_rsp_err"},   {31'b0, rsp_err},   32'h0);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid with empty scoreboard at cycle %0d", cyc);
                end else begin
                    check("rsp_latency", cyc - sb[0].acc, LAT);
                end
            end
            if (rsp_valid && prev_v) begin
                check("hold_rdata", rsp_rdata, prev_d);
                check("hold_err", {31'b0, rsp_err}, {31'b0, prev_e});
                check("hold_req_ready", {31'b0, req_ready}, 32'h0);
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                ex = sb.pop_front();
                check("rsp_rdata", rsp_rdata, ex.d);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, ex.e});
            end
            prev_v = rsp_valid;
            prev_d = rsp_rdata;
            prev_e = rsp_err;
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        check("ready_before_edge", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1;
        check("ready_after_reset", {31'b0, req_ready}, 32'h1);

        // Word write then read back
        wr(32'h8, 32'hDEADBEEF, 4'hF, 1'b0);
        rd(32'h8, 32'hDEADBEEF, 1'b0);

        // Partial low-byte write over a known word
        wr(32'h4, 32'hDEADBEEF, 4'hF, 1'b0);
        wr(32'h4, 32'h00000011, 4'b0001, 1'b0);
        rd(32'h4, 32'hDEADBE11, 1'b0);

        // Errors: misaligned read, index 64 write, word 0 intact
        wr(32'h0, 32'h12345678, 4'hF, 1'b0);
        rd(32'h6, 32'h0, 1'b1);
        wr(32'h100, 32'hFFFFFFFF, 4'hF, 1'b1);
        rd(32'h0, 32'h12345678, 1'b0);
        rd(32'h3, 32'h0, 1'b1);

        // Write with no byte enables is a legal no-op
        wr(32'h8, 32'hFFFFFFFF, 4'h0, 1'b0);
        rd(32'h8, 32'hDEADBEEF, 1'b0);

        // High-byte partial write and the last legal word
        wr(32'h8, 32'hAA000000, 4'b1000, 1'b0);
        rd(32'h8, 32'hAAADBEEF, 1'b0);
        wr(32'hFC, 32'h0BADC0DE, 4'hF, 1'b0);
        rd(32'hFC, 32'h0BADC0DE, 1'b0);
        drain();

        // Backpressure: hold the response for 5 cycles
        rsp_ready = 1'b0;
        rd(32'h4, 32'hDEADBE11, 1'b0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid_held", {31'b0, rsp_valid}, 32'h1);
            check("bp_ready_low", {31'b0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'b0, rsp_valid}, 32'h0);
        check("bp_release_ready", {31'b0, req_ready}, 32'h1);
        drain();

        // Reset in the middle of a write
        wr(32'h10, 32'h55AA55AA, 4'hF, 1'b0);
        rd(32'h10, 32'h55AA55AA, 1'b0);
        drain();
        do_req(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(32'h10, 32'h55AA55AA, 1'b0);
        drain();

`ifdef DMEM_STATS_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) rd(32'h0, 32'h12345678, 1'b0);
        rd(32'h2, 32'h0, 1'b1);
        drain();
        @(posedge clk); #1;
        check("stat_reads", {30'b0, stat_reads}, 32'd3);
        check("stat_errors", {30'b0, stat_errors}, 32'd1);
        check("stat_writes", {30'b0, stat_writes}, 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
